commit_order: RTL and testbench

- Writeback-side companion to the dual-issue steering stage.
- Receives the two pipe results (pipe0 = branch/ALU pipe, pipe1 = memory pipe) with the `first` swap flag carried down the pipeline.
- Restores original program order and drains entries one per cycle through a single commit port (trace/retire interface).
- Buffers in a small circular FIFO and back-pressures issue with `stall` when it cannot accept a full pair.

---
 rtl/commit_order.sv | 141 ++++++++++++++
 tb/tb_commit_order.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/commit_order.sv
// Reorders the two writeback pipe results back into program order and retires them one per cycle.
// Optional macro COMMIT_BYPASS_EN forwards the older incoming entry straight to the commit port when the FIFO is empty.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module commit_order #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pipe0_valid,
    input  logic [`INST_WIDTH-1:0] pipe0_inst,
    input  logic [DATA_WIDTH-1:0]  pipe0_result,
    input  logic                   pipe1_valid,
    input  logic [`INST_WIDTH-1:0] pipe1_inst,
    input  logic [DATA_WIDTH-1:0]  pipe1_result,
    input  logic                   first,
    input  logic                   commit_ready,
    output logic                   commit_valid,
    output logic [`INST_WIDTH-1:0] commit_inst,
    output logic [DATA_WIDTH-1:0]  commit_result,
    output logic                   stall,
    output logic                   overflow,
    output logic [31:0]            commit_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = `INST_WIDTH;
    localparam logic [PW:0] STALL_AT = (PW+1)'(DEPTH - 1);

    logic [IW-1:0]         inst_q   [DEPTH];
    logic [DATA_WIDTH-1:0] result_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           occ_q, occ_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           count_q, count_d;

    logic                  any_valid, both_valid, accept, pop_fifo;
    logic                  bypass_active, bypass_take;
    logic [IW-1:0]         old_inst, yng_inst, a_inst, b_inst;
    logic [DATA_WIDTH-1:0] old_res, yng_res, a_res, b_res;
    logic                  we_a, we_b;
    logic [1:0]            n_push;

    assign any_valid  = pipe0_valid | pipe1_valid;
    assign both_valid = pipe0_valid & pipe1_valid;
    assign stall      = (occ_q >= STALL_AT);
    assign accept     = any_valid && !stall;
    assign pop_fifo   = (occ_q != '0) && commit_ready;

`ifdef COMMIT_BYPASS_EN
    assign bypass_active = (occ_q == '0) && any_valid;
`else
    assign bypass_active = 1'b0;
`endif
    assign bypass_take = bypass_active && commit_ready;

    // A lone valid slot is always "older"; swap only matters when both slots carry work.
    always_comb begin
        old_inst = pipe0_inst;
        old_res  = pipe0_result;
        yng_inst = pipe1_inst;
        yng_res  = pipe1_result;
        if (both_valid && first) begin
            old_inst = pipe1_inst;
            old_res  = pipe1_result;
            yng_inst = pipe0_inst;
            yng_res  = pipe0_result;
        end else if (!pipe0_valid) begin
            old_inst = pipe1_inst;
            old_res  = pipe1_result;
        end
    end

    always_comb begin
        we_a   = 1'b0;
        we_b   = 1'b0;
        a_inst = old_inst;
        a_res  = old_res;
        b_inst = yng_inst;
        b_res  = yng_res;
        n_push = 2'd0;
        if (accept) begin
            if (bypass_take) begin
                // Older entry retires through the bypass; only the younger one is stored.
                a_inst = yng_inst;
                a_res  = yng_res;
                we_a   = both_valid;
                n_push = {1'b0, both_valid};
            end else begin
                we_a   = 1'b1;
                we_b   = both_valid;
                n_push = both_valid ? 2'd2 : 2'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(n_push);
        rd_ptr_d   = rd_ptr_q + PW'(pop_fifo);
        occ_d      = occ_q + (PW+1)'(n_push) - (PW+1)'(pop_fifo);
        count_d    = count_q + 32'(pop_fifo | bypass_take);
        overflow_d = overflow_q | (any_valid & stall);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]   <= '0;
                result_q[i] <= '0;
            end
        end else begin
            if (we_a) begin
                inst_q[wr_ptr_q]   <= a_inst;
                result_q[wr_ptr_q] <= a_res;
            end
            if (we_b) begin
                inst_q[wr_ptr_q + PW'(1)]   <= b_inst;
                result_q[wr_ptr_q + PW'(1)] <= b_res;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    assign commit_valid  = (occ_q != '0) || bypass_active;
    assign commit_inst   = bypass_active ? old_inst : inst_q[rd_ptr_q];
    assign commit_result = bypass_active ? old_res  : result_q[rd_ptr_q];
    assign overflow      = overflow_q;
    assign commit_count  = count_q;

endmodule

// File: tb/tb_commit_order.sv
// Randomised scoreboard bench for commit_order: a program-order queue model predicts every retired entry
// plus stall/overflow/commit_count; a negedge monitor compares the DUT against it.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_commit_order;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int IW    = `INST_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pipe0_valid = 1'b0, pipe1_valid = 1'b0, first = 1'b0, commit_ready = 1'b0;
    logic [IW-1:0] pipe0_inst = '0, pipe1_inst = '0;
    logic [DW-1:0] pipe0_result = '0, pipe1_result = '0;
    logic          commit_valid, stall, overflow;
    logic [IW-1:0] commit_inst;
    logic [DW-1:0] commit_result;
    logic [31:0]   commit_count;

    always #5 clk = ~clk;

    commit_order #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe0_valid(pipe0_valid), .pipe0_inst(pipe0_inst), .pipe0_result(pipe0_result),
        .pipe1_valid(pipe1_valid), .pipe1_inst(pipe1_inst), .pipe1_result(pipe1_result),
        .first(first), .commit_ready(commit_ready),
        .commit_valid(commit_valid), .commit_inst(commit_inst), .commit_result(commit_result),
        .stall(stall), .overflow(overflow), .commit_count(commit_count)
    );

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [DW-1:0] res;
    } ent_t;

    ent_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          occ_m = 0;
    bit          ovf_m = 1'b0;
    logic [31:0] cnt_m = '0;
    int          cur_occ;
    bit          cur_ovf, cur_stall, cur_byp, cur_pop, pending = 1'b0;
    logic [31:0] cur_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model records pre-cycle expectations and the program-order commit stream.
    task automatic cyc(input bit v0, input bit v1, input bit f, input bit rdy);
        ent_t e0, e1;
        bit   stl, byp, pop;
        int   np;
        @(posedge clk);
        #1;
        e0.inst = IW'($urandom); e0.res = DW'($urandom);
        e1.inst = IW'($urandom); e1.res = DW'($urandom);
        pipe0_valid = v0; pipe0_inst = e0.inst; pipe0_result = e0.res;
        pipe1_valid = v1; pipe1_inst = e1.inst; pipe1_result = e1.res;
        first = f; commit_ready = rdy;
        stl = (DEPTH - occ_m) < 2;
`ifdef COMMIT_BYPASS_EN
        byp = (occ_m == 0) && (v0 || v1);
`else
        byp = 1'b0;
`endif
        pop = rdy && (occ_m != 0 || byp);
        cur_occ = occ_m; cur_ovf = ovf_m; cur_cnt = cnt_m;
        cur_stall = stl; cur_byp = byp; cur_pop = pop;
        np = 0;
        if ((v0 || v1) && stl) begin
            ovf_m = 1'b1;
        end else if (v0 || v1) begin
            if (v0 && v1 && f) begin
                exp_q.push_back(e1);
                exp_q.push_back(e0);
            end else begin
                if (v0) exp_q.push_back(e0);
                if (v1) exp_q.push_back(e1);
            end
            np = int'(v0) + int'(v1);
        end
        occ_m = occ_m + np - int'(pop);
        if (pop) cnt_m = cnt_m + 32'd1;
        pending = 1'b1;
    endtask

    always @(negedge clk) begin
        if (pending) begin
            ent_t e;
            pending = 1'b0;
            chk("stall", 64'(stall), 64'(cur_stall));
            chk("commit_valid", 64'(commit_valid), 64'(cur_occ != 0 || cur_byp));
            chk("overflow", 64'(overflow), 64'(cur_ovf));
            chk("commit_count", 64'(commit_count), 64'(cur_cnt));
            if (cur_pop) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_empty actual=commit required=none");
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_inst", 64'(commit_inst), 64'(e.inst));
                    chk("commit_result", 64'(commit_result), 64'(e.res));
                    $display("commit #%0d inst=%0h result=%0h", cur_cnt + 32'd1, commit_inst, commit_result);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) < 6);
    endtask

    task automatic model_reset();
        exp_q.delete();
        occ_m = 0;
        ovf_m = 1'b0;
        cnt_m = '0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_commit_count", 64'(commit_count), 64'd0);
        chk("rst_commit_inst", 64'(commit_inst), 64'd0);
        chk("rst_commit_result", 64'(commit_result), 64'd0);
        reset_n = 1'b1;

        // Directed order cases: pair first=0, pair first=1, lone pipe1 then a pair.
        cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1); idle(3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b0, 1'b1); idle(4);

        // Fill without draining, single push to 7, dropped push, then push 2 / pop 1 at occupancy 6.
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle(10);

        rand_phase(300);
        idle(10);

        // Five buffered entries, then an asynchronous reset between clock edges.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_commit_valid", 64'(commit_valid), 64'd0);
        chk("async_stall", 64'(stall), 64'd0);
        chk("async_overflow", 64'(overflow), 64'd0);
        chk("async_commit_count", 64'(commit_count), 64'd0);
        model_reset();
        pipe0_valid = 1'b0; pipe1_valid = 1'b0; commit_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        rand_phase(200);
        idle(12);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
